// File: rtl/pipe_logic_array.sv
// pipe_logic_array: elastic multi-channel bitwise-logic pipeline.
// Each accepted beat applies AND/OR/XOR/NOR per channel to two operand words.
// The result and its per-channel parity then travel through DEPTH valid/ready stages.
// Empty stages (bubbles) collapse. A synchronous flush clears every valid bit.
// A wrapping counter tallies the completed output handshakes.
module pipe_logic_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic [CHANNELS*WIDTH-1:0] in_a,
    input  logic [CHANNELS*WIDTH-1:0] in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_parity,
    output logic [CNT_W-1:0]          out_count
);

    localparam int DW = CHANNELS * WIDTH;

    typedef enum logic [1:0] {
        OpAnd = 2'd0,
        OpOr  = 2'd1,
        OpXor = 2'd2,
        OpNor = 2'd3
    } op_e;

    // Per-stage state; index DEPTH-1 is the output stage.
    logic [DEPTH-1:0]                v_q, v_d;
    logic [DEPTH-1:0][DW-1:0]        data_q, data_d;
    logic [DEPTH-1:0][CHANNELS-1:0]  par_q, par_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    logic [DW-1:0]                   res;
    logic [CHANNELS-1:0]             res_par;
    logic [DEPTH-1:0]                adv;
    logic                            accept;
    logic                            out_hs;

    // Operand logic: compute each channel's result word and its parity.
    always_comb begin
        logic [WIDTH-1:0] r;
        res     = '0;
        res_par = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r = '0;
            unique case (op_e'(in_op))
                OpAnd: r = in_a[c*WIDTH +: WIDTH] & in_b[c*WIDTH +: WIDTH];
                OpOr:  r = in_a[c*WIDTH +: WIDTH] | in_b[c*WIDTH +: WIDTH];
                OpXor: r = in_a[c*WIDTH +: WIDTH] ^ in_b[c*WIDTH +: WIDTH];
                OpNor: r = ~(in_a[c*WIDTH +: WIDTH] | in_b[c*WIDTH +: WIDTH]);
            endcase
            res[c*WIDTH +: WIDTH] = r;
            res_par[c]            = ^r;
        end
    end

    // Ready chain: stage k may pass its contents on if any later stage has room,
    // or if the sink is ready. The chain is computed with a running OR so that
    // the adv vector has no self-dependency.
    always_comb begin
        logic run;
        adv            = '0;
        run            = out_ready || !v_q[DEPTH-1];
        adv[DEPTH-1]   = run;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            run    = run || !v_q[k+1];
            adv[k] = run;
        end
    end

    assign in_ready = (adv[0] || !v_q[0]) && !flush;
    assign accept   = in_valid && in_ready;
    assign out_hs   = v_q[DEPTH-1] && out_ready;

    // Next-state for the stages: shift on advance, hold otherwise, and let flush clear all valids.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        par_d  = par_q;
        // Stage 0 loads whenever its contents can leave or it is empty.
        if (adv[0] || !v_q[0]) begin
            v_d[0] = accept;
            if (accept) begin
                data_d[0] = res;
                par_d[0]  = res_par;
            end
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (adv[k-1]) begin
                v_d[k] = v_q[k-1];
                // Payload registers only load real beats; bubbles keep stale data.
                if (v_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    par_d[k]  = par_q[k-1];
                end
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    // Output-handshake counter; wraps naturally and ignores flush.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            data_q <= '0;
            par_q  <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            par_q  <= par_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid  = v_q[DEPTH-1];
    assign out_data   = data_q[DEPTH-1];
    assign out_parity = par_q[DEPTH-1];
    assign out_count  = cnt_q;

endmodule

// File: tb/tb_pipe_logic_array.sv
// Self-checking bench for pipe_logic_array.
// The reference model is a FIFO scoreboard of expected beats.
// It also uses an occupancy rule for in_ready and a modular handshake count.
module tb_pipe_logic_array;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 3;
    localparam int CNT_W    = 4;
    localparam int CMASK    = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_parity;
    logic [3:0]  out_count;

    pipe_logic_array #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  p;
    } beat_t;

    int    n_cmp;
    int    n_bad;
    int    exp_cnt;
    int    out_total;
    beat_t sb[$];
    logic  hs_in;
    logic  hs_out;
    logic  smp_v;
    logic [15:0] smp_d;
    logic [1:0]  smp_p;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected beat computed from the operation definition.
    function automatic beat_t ref_beat(input logic [1:0] op, input logic [15:0] a,
                                       input logic [15:0] b);
        beat_t r;
        case (op)
            2'd0:    r.d = a & b;
            2'd1:    r.d = a | b;
            2'd2:    r.d = a ^ b;
            default: r.d = ~(a | b);
        endcase
        for (int c = 0; c < CHANNELS; c++) begin
            r.p[c] = ($countones(r.d[c*WIDTH +: WIDTH]) % 2) == 1;
        end
        return r;
    endfunction

    // One clock cycle: drive at negedge, sample and check, then update the model at posedge.
    task automatic cycle(input logic iv, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ordy, input logic fl);
        beat_t nb;
        @(negedge clk);
        in_valid  = iv;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_eq("in_ready", in_ready, !fl && (ordy || sb.size() < DEPTH));
        check_eq("out_count", out_count, exp_cnt & CMASK);
        smp_v = out_valid;
        smp_d = out_data;
        smp_p = out_parity;
        if (sb.size() == 0) begin
            check_eq("idle_valid", out_valid, 0);
        end else if (out_valid) begin
            check_eq("out_data", out_data, sb[0].d);
            check_eq("out_parity", out_parity, sb[0].p);
        end
        hs_in  = iv && in_ready;
        hs_out = out_valid && ordy;
        nb     = ref_beat(op, a, b);
        @(posedge clk);
        if (hs_out && sb.size() > 0) begin
            void'(sb.pop_front());
            exp_cnt++;
            out_total++;
        end
        if (fl) sb.delete();
        else if (hs_in) sb.push_back(nb);
    endtask

    task automatic drain();
        repeat (8) cycle(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    // Send one beat into an empty pipe, then measure the latency and check the result against constants.
    task automatic send_and_expect(input string tag, input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] ed,
                                   input logic [1:0] ep);
        int n;
        logic found;
        n     = 0;
        found = 1'b0;
        cycle(1'b1, op, a, b, 1'b1, 1'b0);
        check_eq({tag, "_accept"}, hs_in, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0);
            if (smp_v) begin
                found = 1'b1;
                break;
            end
            n++;
        end
        check_eq({tag, "_seen"}, found, 1);
        check_eq({tag, "_latency"}, n, DEPTH - 1);
        check_eq({tag, "_data"}, smp_d, ed);
        check_eq({tag, "_parity"}, smp_p, ep);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        exp_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ba[5];
        logic [15:0] bb[5];
        int idx;
        int base;
        int cnt_before;

        n_cmp = 0; n_bad = 0; exp_cnt = 0; out_total = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0;
        in_a = '0; in_b = '0; out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_parity", out_parity, 0);
        check_eq("rst_count", out_count, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // First beat and its latency.
        send_and_expect("xor0", 2'd2, 16'hF00F, 16'hFFFF, 16'h0FF0, 2'b00);
        #1;
        check_eq("count_first", out_count, 1);

        // Operation coverage.
        send_and_expect("and", 2'd0, 16'hA53C, 16'h0FC3, 16'h0500, 2'b00);
        send_and_expect("or",  2'd1, 16'hA53C, 16'h0FC3, 16'hAFFF, 2'b00);
        send_and_expect("xor", 2'd2, 16'hA53C, 16'h0FC3, 16'hAAFF, 2'b00);
        send_and_expect("nor", 2'd3, 16'hA53C, 16'h0FC3, 16'h5000, 2'b00);
        send_and_expect("par", 2'd1, 16'h0100, 16'h0000, 16'h0100, 2'b10);

        // Backpressure: only DEPTH beats fit while the sink stalls.
        drain();
        for (int i = 0; i < 5; i++) begin
            ba[i] = 16'($urandom());
            bb[i] = 16'($urandom());
        end
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'd2, ba[idx], bb[idx], 1'b0, 1'b0);
            if (hs_in) idx++;
        end
        check_eq("bp_accepted", idx, DEPTH);
        #1;
        check_eq("bp_in_ready", in_ready, 0);
        base = out_total;
        for (int i = 0; i < 5; i++) begin
            cycle(idx < 5, 2'd2, ba[idx % 5], bb[idx % 5], 1'b1, 1'b0);
            if (hs_in) idx++;
        end
        check_eq("bp_drained", out_total - base, 5);
        check_eq("bp_all_in", idx, 5);

        // Bubble collapse: a gap between two beats closes up while the sink stalls.
        drain();
        cycle(1'b1, 2'd0, 16'h1234, 16'hFF00, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 16'h00F0, 16'h0F00, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        check_eq("bubble_full_last", smp_v, 1);
        base = out_total;
        repeat (2) cycle(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0);
        check_eq("bubble_drain", out_total - base, 2);

        // Flush with three beats in flight.
        drain();
        repeat (3) cycle(1'b1, 2'd3, 16'($urandom()), 16'($urandom()), 1'b0, 1'b0);
        cnt_before = exp_cnt;
        cycle(1'b1, 2'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        check_eq("flush_no_accept", hs_in, 0);
        cycle(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        check_eq("flush_cleared", smp_v, 0);
        check_eq("flush_count", out_count, cnt_before & CMASK);
        send_and_expect("post_flush", 2'd0, 16'hC3C3, 16'hFF0F, 16'hC303, 2'b00);

        // Randomized traffic, including occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom()),
                  16'($urandom()), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 24) == 0));
        end
        drain();
        check_eq("rand_drained", sb.size(), 0);

        // Counter wrap at CNT_W=4.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 16'($urandom()), 16'($urandom()), 1'b1, 1'b0);
        end
        drain();
        #1;
        check_eq("wrap_count", out_count, 1);

        // Mid-stream asynchronous reset.
        repeat (2) cycle(1'b1, 2'd2, 16'($urandom()), 16'($urandom()), 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_count", out_count, 0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
